// File: rtl/gain_comp.sv
// Equalizes streaming FFT bins by 1/gain; reciprocal from an on-block restoring divider, swapped in at frame starts.
// Latency: 2 cycles in_valid -> out_valid; coefficient update takes QW cycles after a calvalid rise.
// No backpressure: a sample is accepted on every cycle in_valid is high and is never stalled.
module gain_comp #(
    parameter int DW = 24,
    parameter int GW = 12,
    parameter int GF = 8,
    parameter int RF = 14,
    parameter int QW = GF + RF + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [GW-1:0] gain,
    input  logic          calvalid,
    input  logic          in_valid,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    input  logic          in_last,
    output logic          out_valid,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic          out_last,
    output logic          coef_ok,
    output logic          gain_err,
    output logic          sat
);

    localparam int PW = DW + QW + 1;
    localparam int CW = $clog2(QW);
    localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);
    localparam logic [QW-1:0] UNITY = {{(QW-RF-1){1'b0}}, 1'b1, {RF{1'b0}}};
    localparam logic signed [PW-1:0] RND  = {{(PW-RF){1'b0}}, 1'b1, {(RF-1){1'b0}}};
    localparam logic signed [PW-1:0] YMAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [PW-1:0] YMIN = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        DIV  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Calibration request handling and reciprocal divider
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic          calv_q;
    logic          rise;
    logic [GW-1:0] gain_q, gain_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] rem_q, rem_d;
    logic [QW-1:0] quo_q, quo_d;
    logic [GW:0]   rem_sh;
    logic [GW:0]   rem_sub;
    logic          q_bit;
    logic          div_done;
    logic          gain_err_q;

    assign rise = calvalid & ~calv_q;

    // The dividend is 2^(GF+RF), a QW-bit value whose only set bit is its MSB,
    // so the bit shifted in is 1 on the first iteration and 0 afterwards.
    assign rem_sh  = {rem_q, (cnt_q == '0)};
    assign rem_sub = rem_sh - {1'b0, gain_q};
    assign q_bit   = ~rem_sub[GW];

    // Divider FSM: latch gain on a nonzero rise, then one quotient bit per cycle.
    always_comb begin
        state_d  = state_q;
        gain_d   = gain_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise && (gain != '0)) begin
                    gain_d  = gain;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                if (rise && (gain != '0)) begin
                    // Latest calibration wins: restart with the new gain.
                    gain_d = gain;
                    cnt_d  = '0;
                    rem_d  = '0;
                    quo_d  = '0;
                end else begin
                    rem_d = q_bit ? rem_sub[GW-1:0] : rem_sh[GW-1:0];
                    quo_d = {quo_q[QW-2:0], q_bit};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        div_done = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Pending / active coefficient and frame tracking
    // ------------------------------------------------------------------
    logic [QW-1:0] pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;
    logic [QW-1:0] coef_q, coef_d;
    logic          coef_ok_q, coef_ok_d;
    logic          frame_start_q, frame_start_d;
    logic          swap;
    logic [QW-1:0] coef_use;

    // The first sample of a frame already uses the swapped-in coefficient.
    assign swap     = in_valid & frame_start_q & pend_vld_q;
    assign coef_use = swap ? pend_q : coef_q;

    // Swap at frame start; a fresh divide result always lands in pending, even
    // on the cycle a swap consumes the older one, so it waits for the next frame.
    always_comb begin
        pend_d        = pend_q;
        pend_vld_d    = pend_vld_q;
        coef_d        = coef_q;
        coef_ok_d     = coef_ok_q;
        frame_start_d = frame_start_q;
        if (in_valid) begin
            frame_start_d = in_last;
        end
        if (swap) begin
            coef_d     = pend_q;
            coef_ok_d  = 1'b1;
            pend_vld_d = 1'b0;
        end
        if (div_done) begin
            pend_d     = quo_d;
            pend_vld_d = 1'b1;
        end
    end

    // Control state registers; reset aborts any divide and drops the pending value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            calv_q        <= 1'b0;
            gain_q        <= '0;
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            pend_q        <= '0;
            pend_vld_q    <= 1'b0;
            coef_q        <= UNITY;
            coef_ok_q     <= 1'b0;
            frame_start_q <= 1'b1;
            gain_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            calv_q        <= calvalid;
            gain_q        <= gain_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            pend_q        <= pend_d;
            pend_vld_q    <= pend_vld_d;
            coef_q        <= coef_d;
            coef_ok_q     <= coef_ok_d;
            frame_start_q <= frame_start_d;
            gain_err_q    <= rise & (gain == '0);
        end
    end

    // ------------------------------------------------------------------
    // Datapath: S1 multiply, S2 round + saturate
    // ------------------------------------------------------------------
    logic signed [QW:0]   coef_s;
    logic signed [PW-1:0] p_re_d, p_im_d;
    logic signed [PW-1:0] p_re_q, p_im_q;
    logic                 vld1_q, last1_q;
    logic signed [PW-1:0] r_re, r_im;
    logic [DW-1:0]        y_re, y_im;
    logic                 sat_re, sat_im;
    logic                 out_valid_q, out_last_q, sat_q;
    logic [DW-1:0]        out_re_q, out_im_q;

    assign coef_s = {1'b0, coef_use};
    assign p_re_d = PW'($signed(in_re)) * PW'(coef_s);
    assign p_im_d = PW'($signed(in_im)) * PW'(coef_s);

    // Round half up, then drop the reciprocal's fractional bits.
    assign r_re = (p_re_q + RND) >>> RF;
    assign r_im = (p_im_q + RND) >>> RF;

    // Clip each component into the signed DW-bit output range.
    always_comb begin
        y_re   = r_re[DW-1:0];
        y_im   = r_im[DW-1:0];
        sat_re = 1'b0;
        sat_im = 1'b0;
        if (r_re > YMAX) begin
            y_re   = YMAX[DW-1:0];
            sat_re = 1'b1;
        end else if (r_re < YMIN) begin
            y_re   = YMIN[DW-1:0];
            sat_re = 1'b1;
        end
        if (r_im > YMAX) begin
            y_im   = YMAX[DW-1:0];
            sat_im = 1'b1;
        end else if (r_im < YMIN) begin
            y_im   = YMIN[DW-1:0];
            sat_im = 1'b1;
        end
    end

    // Pipeline registers; output data holds its last value between valid samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_re_q      <= '0;
            p_im_q      <= '0;
            vld1_q      <= 1'b0;
            last1_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            sat_q       <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            vld1_q      <= in_valid;
            last1_q     <= in_valid & in_last;
            if (in_valid) begin
                p_re_q <= p_re_d;
                p_im_q <= p_im_d;
            end
            out_valid_q <= vld1_q;
            out_last_q  <= vld1_q & last1_q;
            sat_q       <= vld1_q & (sat_re | sat_im);
            if (vld1_q) begin
                out_re_q <= y_re;
                out_im_q <= y_im;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_last  = out_last_q;
    assign coef_ok   = coef_ok_q;
    assign gain_err  = gain_err_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_gain_comp.sv
// Scoreboard bench for gain_comp: a cycle-level reference model predicts each output
// sample from the coefficient rules; a separate monitor pops and compares on out_valid.
module tb_gain_comp;

    localparam int DW = 24;
    localparam int QW = 23;
    localparam int RF = 14;
    localparam longint YMAX = 8388607;
    localparam longint YMIN = -8388608;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [11:0]   gain = '0;
    logic          calvalid = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_re = '0;
    logic [DW-1:0] in_im = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;
    logic          out_last;
    logic          coef_ok;
    logic          gain_err;
    logic          sat;

    always #5 clk = ~clk;

    gain_comp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .gain     (gain),
        .calvalid (calvalid),
        .in_valid (in_valid),
        .in_re    (in_re),
        .in_im    (in_im),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_re   (out_re),
        .out_im   (out_im),
        .out_last (out_last),
        .coef_ok  (coef_ok),
        .gain_err (gain_err),
        .sat      (sat)
    );

    typedef struct {
        longint re;
        longint im;
        bit     last;
        bit     sat;
        longint edge_no;
    } exp_t;

    exp_t   sb[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    longint edge_no = 0;

    // reference model state
    longint m_coef = 16384;
    longint m_pend = 0;
    longint m_qv = 0;
    longint m_done_at = -1;
    bit     m_pv = 0;
    bit     m_fs = 1;
    bit     m_ok = 0;
    bit     m_prev = 0;
    bit     m_gerr = 0;
    bit     m_rise;

    task automatic chk(input string name, input longint got, input longint want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, want, $time);
        end
    endtask

    function automatic longint eq(input longint x, input longint c, output bit s);
        longint y;
        y = (x * c + 8192) >>> RF;
        s = 1'b0;
        if (y > YMAX) begin
            y = YMAX;
            s = 1'b1;
        end else if (y < YMIN) begin
            y = YMIN;
            s = 1'b1;
        end
        return y;
    endfunction

    // Reference model: coefficient becomes pending QW edges after an accepted
    // nonzero rise, and is used from the first sample of the following frame.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb.delete();
            m_coef    = 16384;
            m_pv      = 0;
            m_fs      = 1;
            m_ok      = 0;
            m_prev    = 0;
            m_gerr    = 0;
            m_done_at = -1;
        end else begin
            exp_t e;
            bit   sr, si;
            edge_no++;
            m_rise = calvalid && !m_prev;
            if (in_valid) begin
                if (m_fs && m_pv) begin
                    m_coef = m_pend;
                    m_pv   = 0;
                    m_ok   = 1;
                end
                e.re      = eq(longint'($signed(in_re)), m_coef, sr);
                e.im      = eq(longint'($signed(in_im)), m_coef, si);
                e.sat     = sr | si;
                e.last    = in_last;
                e.edge_no = edge_no;
                sb.push_back(e);
                m_fs = in_last;
            end
            m_gerr = m_rise && (gain == 0);
            if (m_rise && (gain != 0)) begin
                m_done_at = edge_no + QW;
                m_qv      = longint'(4194304) / longint'(gain);
            end else if (edge_no == m_done_at) begin
                m_pend = m_qv;
                m_pv   = 1;
            end
            m_prev = calvalid;
        end
    end

    // Monitor: compare status every cycle, pop the scoreboard on out_valid.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {out_valid, out_last, coef_ok, gain_err, sat}, 0);
        end else begin
            chk("coef_ok", coef_ok, m_ok);
            chk("gain_err", gain_err, m_gerr);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_re", longint'($signed(out_re)), e.re);
                    chk("out_im", longint'($signed(out_im)), e.im);
                    chk("out_last", out_last, e.last);
                    chk("sat", sat, e.sat);
                    chk("latency_edges", edge_no - e.edge_no, 1);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int re, input int im, input bit last);
        in_valid = 1'b1;
        in_re    = re[DW-1:0];
        in_im    = im[DW-1:0];
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic cal(input int g);
        gain     = g[11:0];
        calvalid = 1'b1;
        step();
        step();
        calvalid = 1'b0;
        step();
    endtask

    task automatic rnd_send(input bit last);
        bit [31:0] a, b;
        a = $urandom;
        b = $urandom;
        send(int'($signed(a[DW-1:0])), int'($signed(b[DW-1:0])), last);
    endtask

    initial begin
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // unity coefficient after reset
        send(1000, -1000, 0);
        send(-5, 7, 1);
        repeat (3) step();

        // gain 512 -> coef 8192
        cal(512);
        repeat (25) step();
        send(1000, -1001, 0);
        send(200, 301, 1);
        repeat (3) step();

        // gain 768 -> 5461; gain 128 -> saturation both signs
        cal(768);
        repeat (26) step();
        send(3000, -3000, 1);
        cal(128);
        repeat (26) step();
        send(6000000, -6000000, 0);
        send(-6000000, 6000000, 0);
        send(100, -100, 1);
        repeat (3) step();

        // update completing mid-frame
        for (int i = 0; i < 60; i++) begin
            if (i == 5) begin
                gain     = 12'd512;
                calvalid = 1'b1;
            end
            if (i == 10) calvalid = 1'b0;
            rnd_send(i == 59);
        end
        for (int i = 0; i < 3; i++) send(4000 + i, -4000 - i, i == 2);
        repeat (3) step();

        // zero-gain rise, then zero and 256 rises during a divide
        cal(0);
        gain     = 12'd300;
        calvalid = 1'b1;
        step();
        calvalid = 1'b0;
        repeat (3) step();
        cal(0);
        cal(256);
        repeat (30) step();
        send(12345, -12345, 0);
        send(-1, 1, 1);
        repeat (3) step();

        // reset in the middle of a divide
        gain     = 12'd100;
        calvalid = 1'b1;
        repeat (11) step();
        rst_n    = 1'b0;
        calvalid = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (30) step();
        send(7777, -7777, 1);
        repeat (3) step();

        // reset while streaming with a pending coefficient
        cal(200);
        for (int i = 0; i < 30; i++) rnd_send(0);
        in_valid = 1'b1;
        rst_n    = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        send(9999, -9999, 0);
        send(50, 60, 1);
        repeat (3) step();

        // randomized traffic with random calibration requests
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                calvalid = ~calvalid;
                if (calvalid) gain = ($urandom_range(0, 9) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
            end
            if ($urandom_range(0, 9) < 8) rnd_send($urandom_range(0, 15) == 0);
            else step();
        end
        calvalid = 1'b0;
        repeat (6) step();

        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
